pll_loop_ctrl: RTL and testbench

- Parametrised digital loop controller for the all-digital PLL.
- Sits between the bang-bang phase detector (lead/lag) and the DCO control input. Generalises the fixed 4-bit alpha control to a CW-bit word.
- Adds binary-search coarse acquisition, bang-bang tracking, lock detection and loss-of-lock detection.
- Runs entirely in the reference clock domain.

---
 rtl/pll_loop_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pll_loop_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_loop_ctrl.sv
// Digital loop controller for the ADPLL: SAR coarse acquisition, bang-bang tracking, lock/loss-of-lock detection.
// Optional external word override is compiled in with `define PLL_LOOP_CTRL_OVERRIDE_EN (adds ovr_en/ovr_word).
module pll_loop_ctrl #(
  parameter int CW         = 8,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_THR = 4,
  parameter int TRACK_STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pd_valid,
  input  logic          lead,
  input  logic          lag,
`ifdef PLL_LOOP_CTRL_OVERRIDE_EN
  input  logic          ovr_en,
  input  logic [CW-1:0] ovr_word,
`endif
  output logic [CW-1:0] ctrl_word,
  output logic          ctrl_valid,
  output logic          locked,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam int IW = $clog2(CW);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(UNLOCK_THR + 1);

  localparam logic [CW-1:0] MID      = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW:0]   MAX_EXT  = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   STEP_EXT = (CW+1)'(TRACK_STEP);
  localparam logic [IW-1:0] IDX_TOP  = IW'(CW - 1);
  localparam logic [LW-1:0] LOCK_TGT = LW'(LOCK_CNT);
  localparam logic [SW-1:0] SAME_TGT = SW'(UNLOCK_THR);

  logic [IW-1:0] sar_idx, idx_n, idx_dec;
  logic [LW-1:0] lock_cnt, lock_n;
  logic [SW-1:0] same_cnt, same_n;
  logic          dir_valid, dir_valid_n;
  logic          dir_up, dir_up_n;
  logic [1:0]    state_n;
  logic [CW-1:0] word_n;
  logic          locked_n;

  logic          is_up, is_dn, is_dir, in_lock;
  logic [CW:0]   up_ext;
  logic [CW-1:0] up_word, dn_word;

  assign is_up   = lag & ~lead;
  assign is_dn   = lead & ~lag;
  assign is_dir  = is_up | is_dn;
  // HOLD is always in-lock; a direction is in-lock only if it reverses the last real decision
  assign in_lock = ~is_dir | (dir_valid & (dir_up != is_up));
  assign idx_dec = sar_idx - IW'(1);

  assign up_ext  = {1'b0, ctrl_word} + STEP_EXT;
  assign up_word = (up_ext > MAX_EXT) ? {CW{1'b1}} : up_ext[CW-1:0];
  assign dn_word = ({1'b0, ctrl_word} < STEP_EXT) ? {CW{1'b0}} : (ctrl_word - STEP_EXT[CW-1:0]);

  always_comb begin
    state_n     = state;
    word_n      = ctrl_word;
    locked_n    = locked;
    idx_n       = sar_idx;
    lock_n      = lock_cnt;
    same_n      = same_cnt;
    dir_valid_n = dir_valid;
    dir_up_n    = dir_up;
`ifdef PLL_LOOP_CTRL_OVERRIDE_EN
    if (ovr_en) begin
      state_n     = S_IDLE;
      word_n      = ovr_word;
      locked_n    = 1'b0;
      idx_n       = '0;
      lock_n      = '0;
      same_n      = '0;
      dir_valid_n = 1'b0;
    end else
`endif
    if (!enable) begin
      state_n     = S_IDLE;
      locked_n    = 1'b0;
      idx_n       = '0;
      lock_n      = '0;
      same_n      = '0;
      dir_valid_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n     = S_SEARCH;
          word_n      = MID;
          idx_n       = IDX_TOP;
          lock_n      = '0;
          same_n      = '0;
          dir_valid_n = 1'b0;
        end
        S_SEARCH: begin
          if (pd_valid) begin
            if (is_dn) word_n[sar_idx] = 1'b0;
            if (sar_idx != '0) begin
              word_n[idx_dec] = 1'b1;
              idx_n           = idx_dec;
            end else begin
              state_n = S_TRACK;
            end
            if (is_dir) begin
              dir_valid_n = 1'b1;
              dir_up_n    = is_up;
            end
          end
        end
        default: begin
          // TRACK and LOCKED share the word update; only the lock transitions differ
          if (pd_valid) begin
            if (is_up)      word_n = up_word;
            else if (is_dn) word_n = dn_word;
            if (is_dir) begin
              dir_valid_n = 1'b1;
              dir_up_n    = is_up;
            end
            if (in_lock) begin
              lock_n = (lock_cnt == LOCK_TGT) ? lock_cnt : lock_cnt + LW'(1);
              same_n = is_dir ? SW'(1) : '0;
            end else begin
              lock_n = '0;
              same_n = (same_cnt == SAME_TGT) ? same_cnt : same_cnt + SW'(1);
            end
            if (state == S_TRACK && lock_n == LOCK_TGT) begin
              state_n  = S_LOCKED;
              locked_n = 1'b1;
            end
            if (state == S_LOCKED && same_n == SAME_TGT) begin
              state_n  = S_TRACK;
              locked_n = 1'b0;
              lock_n   = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ctrl_word  <= MID;
      ctrl_valid <= 1'b0;
      locked     <= 1'b0;
      sar_idx    <= '0;
      lock_cnt   <= '0;
      same_cnt   <= '0;
      dir_valid  <= 1'b0;
      dir_up     <= 1'b0;
    end else begin
      state      <= state_n;
      ctrl_word  <= word_n;
      ctrl_valid <= (word_n != ctrl_word);
      locked     <= locked_n;
      sar_idx    <= idx_n;
      lock_cnt   <= lock_n;
      same_cnt   <= same_n;
      dir_valid  <= dir_valid_n;
      dir_up     <= dir_up_n;
    end
  end

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Directed self-checking bench for pll_loop_ctrl (CW=8, LOCK_CNT=16, UNLOCK_THR=4, TRACK_STEP=1).
module tb_pll_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pd_valid;
  logic       lead;
  logic       lag;
  logic [7:0] ctrl_word;
  logic       ctrl_valid;
  logic       locked;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic       sar_dn    [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] sar_words [8] = '{8'h40, 8'h60, 8'h70, 8'h68, 8'h6C, 8'h6E, 8'h6F, 8'h6E};
  logic [7:0] up_words  [8] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};
  logic [7:0] dn_words  [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  pll_loop_ctrl #(.CW(8), .LOCK_CNT(16), .UNLOCK_THR(4), .TRACK_STEP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pd_valid  (pd_valid),
    .lead      (lead),
    .lag       (lag),
    .ctrl_word (ctrl_word),
    .ctrl_valid(ctrl_valid),
    .locked    (locked),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pd(input logic dn, input logic up);
    pd_valid = 1'b1;
    lead     = dn;
    lag      = up;
    tick();
    pd_valid = 1'b0;
    lead     = 1'b0;
    lag      = 1'b0;
  endtask

  // Leave whatever state we are in and start a fresh search from midscale.
  task automatic restart_search(input logic expect_pulse);
    enable = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0) begin errors++; $display("[TB] FAIL restart_idle_state: got %0d expected 0", state); end
    enable = 1'b1;
    tick();
    checks++;
    if (ctrl_word !== 8'h80 || state !== 2'd1 || ctrl_valid !== expect_pulse) begin
      errors++;
      $display("[TB] FAIL restart_search: word=%h state=%0d valid=%b expected 80/1/%b", ctrl_word, state, ctrl_valid, expect_pulse);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; pd_valid = 1'b0; lead = 1'b0; lag = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (ctrl_word !== 8'h80) begin errors++; $display("[TB] FAIL reset_word: got %h expected 80", ctrl_word); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ctrl_valid); end
  endtask

  task automatic test_sar(input string tag);
    for (int i = 0; i < 8; i++) begin
      pd(sar_dn[i], !sar_dn[i]);
      checks++;
      if (ctrl_word !== sar_words[i]) begin errors++; $display("[TB] FAIL %s_word[%0d]: got %h expected %h", tag, i, ctrl_word, sar_words[i]); end
      checks++;
      if (ctrl_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s_valid[%0d]: got %b expected 1", tag, i, ctrl_valid); end
      checks++;
      if (state !== ((i == 7) ? 2'd2 : 2'd1)) begin errors++; $display("[TB] FAIL %s_state[%0d]: got %0d", tag, i, state); end
    end
  endtask

  task automatic test_lock(input string tag);
    for (int i = 0; i < 16; i++) begin
      logic       up;
      logic [7:0] exp_word;
      up       = (i % 2 == 0);
      exp_word = up ? 8'h6F : 8'h6E;
      pd(!up, up);
      checks++;
      if (ctrl_word !== exp_word || ctrl_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_word[%0d]: word=%h valid=%b expected %h/1", tag, i, ctrl_word, ctrl_valid, exp_word);
      end
      checks++;
      if (locked !== (i == 15) || state !== ((i == 15) ? 2'd3 : 2'd2)) begin
        errors++;
        $display("[TB] FAIL %s_lock[%0d]: locked=%b state=%0d", tag, i, locked, state);
      end
    end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_word;
      exp_word = 8'h6F + 8'(i);
      pd(1'b0, 1'b1);
      checks++;
      if (ctrl_word !== exp_word) begin errors++; $display("[TB] FAIL unlock_word[%0d]: got %h expected %h", i, ctrl_word, exp_word); end
      checks++;
      if (locked !== (i != 3) || state !== ((i == 3) ? 2'd2 : 2'd3)) begin
        errors++;
        $display("[TB] FAIL unlock_state[%0d]: locked=%b state=%0d", i, locked, state);
      end
    end
  endtask

  task automatic test_saturation();
    restart_search(1'b1);
    for (int i = 0; i < 8; i++) begin
      pd(1'b0, 1'b1);
      checks++;
      if (ctrl_word !== up_words[i] || ctrl_valid !== (i != 7)) begin
        errors++;
        $display("[TB] FAIL sat_up_sar[%0d]: word=%h valid=%b expected %h", i, ctrl_word, ctrl_valid, up_words[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      pd(1'b0, 1'b1);
      checks++;
      if (ctrl_word !== 8'hFF || ctrl_valid !== 1'b0 || state !== 2'd2) begin
        errors++;
        $display("[TB] FAIL sat_top[%0d]: word=%h valid=%b state=%0d expected ff/0/2", i, ctrl_word, ctrl_valid, state);
      end
    end
    restart_search(1'b1);
    for (int i = 0; i < 8; i++) begin
      pd(1'b1, 1'b0);
      checks++;
      if (ctrl_word !== dn_words[i] || ctrl_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sat_dn_sar[%0d]: word=%h valid=%b expected %h/1", i, ctrl_word, ctrl_valid, dn_words[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      pd(1'b1, 1'b0);
      checks++;
      if (ctrl_word !== 8'h00 || ctrl_valid !== 1'b0 || state !== 2'd2) begin
        errors++;
        $display("[TB] FAIL sat_bottom[%0d]: word=%h valid=%b state=%0d expected 00/0/2", i, ctrl_word, ctrl_valid, state);
      end
    end
  endtask

  task automatic test_abort();
    restart_search(1'b1);
    pd(1'b1, 1'b0);
    pd(1'b0, 1'b1);
    pd(1'b0, 1'b1);
    checks++;
    if (ctrl_word !== 8'h70) begin errors++; $display("[TB] FAIL abort_partial: got %h expected 70", ctrl_word); end
    // enable drops together with a DN decision; the decision must be ignored
    enable = 1'b0;
    pd(1'b1, 1'b0);
    checks++;
    if (state !== 2'd0 || ctrl_word !== 8'h70 || ctrl_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: state=%0d word=%h valid=%b locked=%b expected 0/70/0/0", state, ctrl_word, ctrl_valid, locked);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (state !== 2'd1 || ctrl_word !== 8'h80 || ctrl_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_resume: state=%0d word=%h valid=%b expected 1/80/1", state, ctrl_word, ctrl_valid);
    end
    test_sar("abort_sar");
    test_lock("abort_lock");
  endtask

  task automatic test_hold_and_reset();
    pd(1'b1, 1'b1);
    checks++;
    if (ctrl_word !== 8'h6E || ctrl_valid !== 1'b0 || state !== 2'd3) begin
      errors++;
      $display("[TB] FAIL hold_locked: word=%h valid=%b state=%0d expected 6e/0/3", ctrl_word, ctrl_valid, state);
    end
    lag = 1'b1;
    tick();
    lag = 1'b0;
    checks++;
    if (ctrl_word !== 8'h6E || ctrl_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_strobe: word=%h valid=%b expected 6e/0", ctrl_word, ctrl_valid);
    end
    rst = 1'b1;
    pd(1'b0, 1'b1);
    rst = 1'b0;
    checks++;
    if (ctrl_word !== 8'h80 || ctrl_valid !== 1'b0 || locked !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_locked: word=%h valid=%b locked=%b state=%0d expected 80/0/0/0", ctrl_word, ctrl_valid, locked, state);
    end
  endtask

  initial begin
    test_reset();
    enable = 1'b1;
    tick();
    checks++;
    if (state !== 2'd1 || ctrl_word !== 8'h80 || ctrl_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enter_search: state=%0d word=%h valid=%b expected 1/80/0", state, ctrl_word, ctrl_valid);
    end
    test_sar("sar");
    test_lock("lock");
    test_unlock();
    test_saturation();
    test_abort();
    test_hold_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
